// File: rtl/frame_dump_ctrl.sv
// UART command sequencer: snap/dump commands drive fifo_capture and stream the frame to uart_tx.
// Build option FRAME_HEADER_EN prefixes each dump with A5 5A and the 24-bit frame length.
//
// state    | meaning
// IDLE     | waiting for a host command byte
// CAP_GO   | pulse capture_start
// CAP_ARM  | wait for fifo to report busy
// CAP_WAIT | wait for capture to finish
// RD_GO    | pulse read_start, clear byte counter
// RD_WAIT  | wait for read-pointer reset done
// HDR      | load next header byte (header builds only)
// STROBE   | pulse rd_byte_str
// DWAIT    | wait for fifo byte, latch into tx_data
// TXQ      | wait for uart idle, pulse tx_en
// TXARM    | one cycle for uart to raise busy
// TXWAIT   | wait for uart idle, pick next step
// ACK      | load ACK_BYTE for transmission
module frame_dump_ctrl #(
  parameter int unsigned FRAME_BYTES = 153600,
  parameter logic [7:0]  CMD_SNAP    = 8'h53,
  parameter logic [7:0]  CMD_DUMP    = 8'h44,
  parameter logic [7:0]  ACK_BYTE    = 8'h4B,
  parameter logic [7:0]  ERR_BYTE    = 8'h45,
  parameter int unsigned TIMEOUT_CYC = 4800000
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_rx_done,
  input  logic [7:0] i_rx_data,
  output logic [7:0] o_tx_data,
  output logic       o_tx_en,
  input  logic       i_tx_busy,
  input  logic       i_fifo_busy,
  output logic       o_capture_start,
  output logic       o_read_start,
  input  logic       i_fifo_rrst_done,
  output logic       o_rd_byte_str,
  input  logic       i_data_ready,
  input  logic [7:0] i_data,
  output logic       o_busy,
  output logic       o_err
);

  localparam int CW = $clog2(FRAME_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_BYTES - 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CAP_GO, S_CAP_ARM, S_CAP_WAIT, S_RD_GO, S_RD_WAIT, S_HDR,
    S_STROBE, S_DWAIT, S_TXQ, S_TXARM, S_TXWAIT, S_ACK
  } state_t;

  // What the byte currently in the TXQ/TXARM/TXWAIT path is, so TXWAIT knows where to go next.
  typedef enum logic [1:0] {K_DATA, K_HDR, K_ACK, K_ERR} kind_t;

  state_t          state;
  kind_t           kind;
  logic [CW-1:0]   byte_cnt;
  logic [TW-1:0]   tmo;

`ifdef FRAME_HEADER_EN
  localparam logic [23:0] FB24 = 24'(FRAME_BYTES);
  logic [2:0] hdr_idx;

  function automatic logic [7:0] hdr_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    hdr_byte = 8'hA5;
      3'd1:    hdr_byte = 8'h5A;
      3'd2:    hdr_byte = FB24[23:16];
      3'd3:    hdr_byte = FB24[15:8];
      default: hdr_byte = FB24[7:0];
    endcase
  endfunction
`endif

  function automatic logic timed(input state_t s);
    return s inside {S_CAP_ARM, S_CAP_WAIT, S_RD_WAIT, S_DWAIT, S_TXQ, S_TXWAIT};
  endfunction

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state           <= S_IDLE;
      kind            <= K_DATA;
      o_tx_data       <= '0;
      o_tx_en         <= 1'b0;
      o_capture_start <= 1'b0;
      o_read_start    <= 1'b0;
      o_rd_byte_str   <= 1'b0;
      o_busy          <= 1'b0;
      o_err           <= 1'b0;
      byte_cnt        <= '0;
      tmo             <= '0;
`ifdef FRAME_HEADER_EN
      hdr_idx         <= '0;
`endif
    end else begin
      o_tx_en         <= 1'b0;
      o_capture_start <= 1'b0;
      o_read_start    <= 1'b0;
      o_rd_byte_str   <= 1'b0;
      // Timer reloads by default; only a wait state that stays put counts down.
      tmo             <= TMO_LOAD;
      if (timed(state) && tmo == '0) begin
        o_err <= 1'b1;
        if (kind != K_ERR && !i_tx_busy) begin
          o_tx_data <= ERR_BYTE;
          kind      <= K_ERR;
          state     <= S_TXQ;
        end else begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      end else begin
        case (state)
          S_IDLE:
            if (i_rx_done && (i_rx_data == CMD_SNAP || i_rx_data == CMD_DUMP)) begin
              o_err  <= 1'b0;
              o_busy <= 1'b1;
              kind   <= K_DATA;
              state  <= (i_rx_data == CMD_SNAP) ? S_CAP_GO : S_RD_GO;
            end
          S_CAP_GO: begin
            o_capture_start <= 1'b1;
            state           <= S_CAP_ARM;
          end
          S_CAP_ARM:
            if (i_fifo_busy) state <= S_CAP_WAIT;
            else             tmo   <= tmo - TW'(1);
          S_CAP_WAIT:
            if (!i_fifo_busy) state <= S_RD_GO;
            else              tmo   <= tmo - TW'(1);
          S_RD_GO: begin
            o_read_start <= 1'b1;
            byte_cnt     <= '0;
            state        <= S_RD_WAIT;
          end
          S_RD_WAIT:
            if (i_fifo_rrst_done) begin
`ifdef FRAME_HEADER_EN
              hdr_idx <= '0;
              state   <= S_HDR;
`else
              state   <= S_STROBE;
`endif
            end else begin
              tmo <= tmo - TW'(1);
            end
          S_HDR: begin
`ifdef FRAME_HEADER_EN
            o_tx_data <= hdr_byte(hdr_idx);
            kind      <= K_HDR;
            state     <= S_TXQ;
`else
            state     <= S_STROBE;
`endif
          end
          S_STROBE: begin
            o_rd_byte_str <= 1'b1;
            kind          <= K_DATA;
            state         <= S_DWAIT;
          end
          S_DWAIT:
            if (i_data_ready) begin
              o_tx_data <= i_data;
              state     <= S_TXQ;
            end else begin
              tmo <= tmo - TW'(1);
            end
          S_TXQ:
            if (!i_tx_busy) begin
              o_tx_en <= 1'b1;
              state   <= S_TXARM;
            end else begin
              tmo <= tmo - TW'(1);
            end
          S_TXARM:
            state <= S_TXWAIT;
          S_TXWAIT:
            if (!i_tx_busy) begin
              case (kind)
                K_DATA: begin
                  byte_cnt <= byte_cnt + CW'(1);
                  state    <= (byte_cnt == CNT_LAST) ? S_ACK : S_STROBE;
                end
`ifdef FRAME_HEADER_EN
                K_HDR:
                  if (hdr_idx == 3'd4) begin
                    state <= S_STROBE;
                  end else begin
                    hdr_idx <= hdr_idx + 3'd1;
                    state   <= S_HDR;
                  end
`endif
                default: begin
                  state  <= S_IDLE;
                  o_busy <= 1'b0;
                end
              endcase
            end else begin
              tmo <= tmo - TW'(1);
            end
          S_ACK: begin
            o_tx_data <= ACK_BYTE;
            kind      <= K_ACK;
            state     <= S_TXQ;
          end
          default: begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
